fetch_issue_unit: RTL

Instruction-side producer for the five-stage pipeline. It holds a writable instruction memory and a program counter, and drives one 32-bit instruction word per clock into the IF/ID buffer. After every real instruction it inserts a fixed number of NOP bubbles, so that a forwarding-free pipeline never sees a RAW hazard. It replaces hand-fed instruction stimulus with an autonomous fetch sequencer.

---
 rtl/isa_pkg.sv | 24 ++
 rtl/instr_mem.sv | 25 ++
 rtl/fetch_issue_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants, instruction field positions and the fetch FSM encoding.
// The control unit and decoder reuse the field positions defined here.
package isa_pkg;

    localparam logic [31:0] NOP_WORD  = 32'hA800_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 29;
    localparam int RDST_MSB = 23;
    localparam int RDST_LSB = 21;
    localparam int RSRC_MSB = 20;
    localparam int RSRC_LSB = 18;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_HALT   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a program survives a pipeline reset.
module instr_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_issue_unit.sv
// Autonomous fetch sequencer: issues one instruction followed by NOP_SLOTS
// bubbles into the IF/ID buffer, stopping on HALT_WORD or at end of memory.
module fetch_issue_unit
    import isa_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 8,
    parameter int NOP_SLOTS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic              issuing,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        CNT_LOAD = 3'(NOP_SLOTS);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic [2:0]        cnt, cnt_n;
    logic              eom, eom_n;
    logic [31:0]       instr_p0, instr_n;
    logic [31:0]       rd_word;
    logic              mem_we;

    // Programming is only safe while nothing is being issued.
    assign mem_we = prog_we && ((state == ST_IDLE) || (state == ST_HALT));

    instr_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (rd_word)
    );

    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        cnt_n   = cnt;
        eom_n   = eom;
        instr_n = instr_p0;
        if (!stall) begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    instr_n = NOP_WORD;
                    if (start) begin
                        state_n = ST_FETCH;
                        pc_n    = '0;
                        eom_n   = 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (rd_word == HALT_WORD) begin
                        instr_n = NOP_WORD;
                        state_n = ST_HALT;
                    end else begin
                        instr_n = rd_word;
                        // The last word does not wrap; it finishes its bubbles, then halts.
                        if (pc_q == PC_LAST) begin
                            eom_n = 1'b1;
                        end else begin
                            pc_n = pc_q + 1'b1;
                        end
                        if (NOP_SLOTS == 0) begin
                            state_n = (pc_q == PC_LAST) ? ST_HALT : ST_FETCH;
                        end else begin
                            state_n = ST_BUBBLE;
                            cnt_n   = CNT_LOAD;
                        end
                    end
                end
                ST_BUBBLE: begin
                    instr_n = NOP_WORD;
                    cnt_n   = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_n = eom ? ST_HALT : ST_FETCH;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    instr_n = NOP_WORD;
                end
            endcase
        end
    end

    // Stage boundary: output register feeding the IF/ID buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc_q     <= '0;
            cnt      <= '0;
            eom      <= 1'b0;
            instr_p0 <= NOP_WORD;
        end else begin
            state    <= state_n;
            pc_q     <= pc_n;
            cnt      <= cnt_n;
            eom      <= eom_n;
            instr_p0 <= instr_n;
        end
    end

    assign instr   = instr_p0;
    assign pc      = pc_q;
    assign issuing = (state == ST_FETCH) || (state == ST_BUBBLE);
    assign halted  = (state == ST_HALT);

endmodule
